// File: rtl/icache_fill.sv
// icache_fill: critical-word-first instruction-cache line refill engine.
// Issues one wrapping burst per miss, writes each beat into the victim CAM
// way and returns the requested word as soon as its beat arrives.
module icache_fill #(
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2,
    parameter int PADDR_W    = 29,
    localparam int WAYW      = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFFW      = $clog2(LINE_WORDS),
    localparam int AW        = PADDR_W - 2,
    localparam int TAGW      = AW - OFFW
) (
    input  logic            clk_core,
    input  logic            reset_n,
    input  logic            fill_req,
    input  logic [AW-1:0]   fill_addr,
    input  logic            kill,
    output logic            icf_busy,
    output logic            icf_insn_valid,
    output logic [31:0]     icf_insn,
    output logic            icf_exc,
    output logic            icf_cam_write_req,
    output logic [WAYW-1:0] icf_cam_write_way,
    output logic [OFFW-1:0] icf_cam_write_offset,
    output logic [TAGW-1:0] icf_cam_write_tag,
    output logic [31:0]     icf_cam_write_data,
    output logic            icf_cam_line_valid,
    output logic            icf_cvalid,
    input  logic            bmain_cready,
    output logic            icf_cmd,
    output logic [AW-1:0]   icf_addr,
    input  logic            bmain_rvalid,
    output logic            icf_rready,
    input  logic            bmain_rlast,
    input  logic [31:0]     bmain_rdata,
    input  logic            bmain_error,
    output logic            icf_eack
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    localparam logic [OFFW-1:0] LAST = OFFW'(LINE_WORDS - 1);

    state_t          state;
    logic [AW-1:0]   lat_addr;
    logic [OFFW-1:0] count;
    logic            killed;
    logic [WAYW-1:0] victim;
    logic [WAYW-1:0] victim_next;
    logic            live;
    logic            beat;

    // Next victim way; a single-way cache always refills way 0.
    always_comb begin
        victim_next = '0;
        if (WAYS > 1) begin
            victim_next = victim + WAYW'(1);
        end
    end

    // A fill is live when neither an earlier nor a same-cycle kill has hit it.
    always_comb begin
        live = ~(killed | kill);
        beat = (state == S_DATA) & bmain_rvalid & ~bmain_error;
    end

    // Refill sequencer: command issue, beat counting, kill drain and error exits.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            lat_addr       <= '0;
            count          <= '0;
            killed         <= 1'b0;
            victim         <= '0;
            icf_insn       <= '0;
            icf_insn_valid <= 1'b0;
            icf_exc        <= 1'b0;
        end else begin
            icf_insn_valid <= 1'b0;
            icf_exc        <= 1'b0;
            case (state)
                S_IDLE: begin
                    killed <= 1'b0;
                    if (fill_req && !kill) begin
                        lat_addr <= fill_addr;
                        state    <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (kill) begin
                        killed <= 1'b1;
                    end
                    if (bmain_error) begin
                        icf_exc <= live;
                        killed  <= 1'b0;
                        state   <= S_IDLE;
                    end else if (bmain_cready) begin
                        count <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (kill) begin
                        killed <= 1'b1;
                    end
                    if (bmain_error) begin
                        icf_exc <= live;
                        killed  <= 1'b0;
                        state   <= S_IDLE;
                    end else if (bmain_rvalid) begin
                        if (count == '0) begin
                            icf_insn       <= bmain_rdata;
                            icf_insn_valid <= live;
                        end
                        if (count == LAST) begin
                            // Line is only committed if the bus closes the burst correctly.
                            if (bmain_rlast) begin
                                if (!killed) begin
                                    victim <= victim_next;
                                end
                            end else begin
                                icf_exc <= live;
                            end
                            killed <= 1'b0;
                            state  <= S_IDLE;
                        end else if (bmain_rlast) begin
                            icf_exc <= live;
                            killed  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            count <= count + OFFW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus handshake and CAM write strobes derived from the current state and beat.
    always_comb begin
        icf_busy             = (state != S_IDLE);
        icf_cvalid           = (state == S_CMD);
        icf_rready           = (state == S_DATA);
        icf_cmd              = 1'b1;
        icf_addr             = lat_addr;
        icf_eack             = (state != S_IDLE) & bmain_error;
        icf_cam_write_req    = beat & ~killed;
        icf_cam_write_way    = victim;
        icf_cam_write_offset = lat_addr[OFFW-1:0] + count;
        icf_cam_write_tag    = lat_addr[AW-1:OFFW];
        icf_cam_write_data   = '0;
        if (beat && !killed) begin
            icf_cam_write_data = bmain_rdata;
        end
        icf_cam_line_valid   = beat & ~killed & (count == LAST) & bmain_rlast;
    end

endmodule

// File: tb/tb_icache_fill.sv
// tb_icache_fill: randomized directed bench for icache_fill with a bus-side
// reference model; covers a 4x2 and an 8x4 configuration.
module tb_icache_fill;

    localparam int AW = 27;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic          reset_n;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          kill;
    logic          bmain_cready;
    logic          bmain_rvalid;
    logic          bmain_rlast;
    logic [31:0]   bmain_rdata;
    logic          bmain_error;

    logic a_busy, a_iv, a_exc, a_wr, a_lv, a_cv, a_cmd, a_rr, a_eack;
    logic [31:0] a_insn, a_wdata;
    logic [0:0]  a_way;
    logic [1:0]  a_off;
    logic [24:0] a_tag;
    logic [AW-1:0] a_addr;

    logic b_busy, b_iv, b_exc, b_wr, b_lv, b_cv, b_cmd, b_rr, b_eack;
    logic [31:0] b_insn, b_wdata;
    logic [1:0]  b_way;
    logic [2:0]  b_off;
    logic [23:0] b_tag;
    logic [AW-1:0] b_addr;

    icache_fill #(.LINE_WORDS(4), .WAYS(2), .PADDR_W(29)) dut_a (
        .clk_core(clk_core), .reset_n(reset_n), .fill_req(fill_req), .fill_addr(fill_addr),
        .kill(kill), .icf_busy(a_busy), .icf_insn_valid(a_iv), .icf_insn(a_insn), .icf_exc(a_exc),
        .icf_cam_write_req(a_wr), .icf_cam_write_way(a_way), .icf_cam_write_offset(a_off),
        .icf_cam_write_tag(a_tag), .icf_cam_write_data(a_wdata), .icf_cam_line_valid(a_lv),
        .icf_cvalid(a_cv), .bmain_cready(bmain_cready), .icf_cmd(a_cmd), .icf_addr(a_addr),
        .bmain_rvalid(bmain_rvalid), .icf_rready(a_rr), .bmain_rlast(bmain_rlast),
        .bmain_rdata(bmain_rdata), .bmain_error(bmain_error), .icf_eack(a_eack)
    );

    icache_fill #(.LINE_WORDS(8), .WAYS(4), .PADDR_W(29)) dut_b (
        .clk_core(clk_core), .reset_n(reset_n), .fill_req(fill_req), .fill_addr(fill_addr),
        .kill(kill), .icf_busy(b_busy), .icf_insn_valid(b_iv), .icf_insn(b_insn), .icf_exc(b_exc),
        .icf_cam_write_req(b_wr), .icf_cam_write_way(b_way), .icf_cam_write_offset(b_off),
        .icf_cam_write_tag(b_tag), .icf_cam_write_data(b_wdata), .icf_cam_line_valid(b_lv),
        .icf_cvalid(b_cv), .bmain_cready(bmain_cready), .icf_cmd(b_cmd), .icf_addr(b_addr),
        .bmain_rvalid(bmain_rvalid), .icf_rready(b_rr), .bmain_rlast(bmain_rlast),
        .bmain_rdata(bmain_rdata), .bmain_error(bmain_error), .icf_eack(b_eack)
    );

    // Selected-configuration view of the outputs (sel=0: 4x2, sel=1: 8x4).
    bit sel;
    logic o_busy, o_iv, o_exc, o_wr, o_lv, o_cv, o_cmd, o_rr, o_eack;
    logic [31:0] o_insn, o_wdata;
    logic [2:0]  o_way;
    logic [3:0]  o_off;
    logic [26:0] o_tag;
    logic [AW-1:0] o_addr;

    always_comb begin
        if (!sel) begin
            o_busy = a_busy; o_iv = a_iv; o_exc = a_exc; o_wr = a_wr; o_lv = a_lv;
            o_cv = a_cv; o_cmd = a_cmd; o_rr = a_rr; o_eack = a_eack; o_insn = a_insn;
            o_wdata = a_wdata; o_way = {2'b0, a_way}; o_off = {2'b0, a_off};
            o_tag = {2'b0, a_tag}; o_addr = a_addr;
        end else begin
            o_busy = b_busy; o_iv = b_iv; o_exc = b_exc; o_wr = b_wr; o_lv = b_lv;
            o_cv = b_cv; o_cmd = b_cmd; o_rr = b_rr; o_eack = b_eack; o_insn = b_insn;
            o_wdata = b_wdata; o_way = {1'b0, b_way}; o_off = {1'b0, b_off};
            o_tag = {3'b0, b_tag}; o_addr = b_addr;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference state: victim way, pending one-cycle pulses and the expected instruction.
    int          vic;
    logic        exp_iv;
    logic        exp_exc;
    logic [31:0] exp_insn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic chk_pulses();
        chk("insn_valid", 64'(o_iv), 64'(exp_iv));
        if (exp_iv) chk("insn", 64'(o_insn), 64'(exp_insn));
        chk("exc", 64'(o_exc), 64'(exp_exc));
        exp_iv  = 1'b0;
        exp_exc = 1'b0;
    endtask

    task automatic quiet_inputs();
        fill_req = 1'b0; kill = 1'b0; bmain_cready = 1'b0; bmain_rvalid = 1'b0;
        bmain_rlast = 1'b0; bmain_error = 1'b0; bmain_rdata = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(o_busy), 0);
        chk({tag, "_iv"}, 64'(o_iv), 0);
        chk({tag, "_exc"}, 64'(o_exc), 0);
        chk({tag, "_wr"}, 64'(o_wr), 0);
        chk({tag, "_lv"}, 64'(o_lv), 0);
        chk({tag, "_cvalid"}, 64'(o_cv), 0);
        chk({tag, "_rready"}, 64'(o_rr), 0);
        chk({tag, "_eack"}, 64'(o_eack), 0);
        chk({tag, "_insn"}, 64'(o_insn), 0);
        chk({tag, "_wdata"}, 64'(o_wdata), 0);
        chk({tag, "_addr"}, 64'(o_addr), 0);
        chk({tag, "_way"}, 64'(o_way), 0);
        chk({tag, "_cmd"}, 64'(o_cmd), 1);
    endtask

    task automatic idle_cycle();
        quiet_inputs();
        @(negedge clk_core);
        chk("idle_busy", 64'(o_busy), 0);
        chk("idle_wr", 64'(o_wr), 0);
        chk_pulses();
        step();
    endtask

    // One refill from the bus side. gap: 0 rvalid always, 1 every other cycle, 2 random.
    // err_beat / early / rst_beat select the beat where an error, early rlast or reset hits (-1: none).
    task automatic do_fill(input int unsigned a, input int cwait, input int gap, input bit kill_cmd,
                           input int err_beat, input int early, input int rst_beat,
                           input bit use_crit, input logic [31:0] crit);
        int L, nw, offw, k, dcyc, nwr;
        bit killed, done, rv;
        logic [31:0] d;
        L    = sel ? 8 : 4;
        nw   = sel ? 4 : 2;
        offw = sel ? 3 : 2;
        quiet_inputs();
        fill_req  = 1'b1;
        fill_addr = AW'(a);
        @(negedge clk_core);
        chk("req_busy", 64'(o_busy), 0);
        chk("req_cvalid", 64'(o_cv), 0);
        chk("req_wr", 64'(o_wr), 0);
        chk_pulses();
        step();
        fill_req  = 1'b0;
        fill_addr = AW'($urandom);
        killed    = kill_cmd;
        for (int w = 0; w <= cwait; w++) begin
            bmain_cready = (w == cwait);
            kill         = kill_cmd && (w == 0);
            @(negedge clk_core);
            chk("cmd_cvalid", 64'(o_cv), 1);
            chk("cmd_addr", 64'(o_addr), 64'(a));
            chk("cmd_busy", 64'(o_busy), 1);
            chk("cmd_rready", 64'(o_rr), 0);
            chk("cmd_wr", 64'(o_wr), 0);
            chk_pulses();
            step();
        end
        quiet_inputs();
        k = 0; dcyc = 0; nwr = 0; done = 1'b0;
        while (!done && dcyc < 200) begin
            case (gap)
                0:       rv = 1'b1;
                1:       rv = (dcyc % 2) == 1;
                default: rv = 1'($urandom_range(0, 1));
            endcase
            dcyc++;
            quiet_inputs();
            bmain_rdata = $urandom;
            if (rv && k == err_beat) begin
                bmain_error = 1'b1;
                @(negedge clk_core);
                chk("err_eack", 64'(o_eack), 1);
                chk("err_wr", 64'(o_wr), 0);
                chk("err_lv", 64'(o_lv), 0);
                chk_pulses();
                exp_exc = !killed;
                done = 1'b1;
            end else if (rv && k == rst_beat) begin
                bmain_rvalid = 1'b1;
                #2;
                reset_n = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                @(negedge clk_core);
                reset_n = 1'b1;
                vic = 0; exp_iv = 1'b0; exp_exc = 1'b0;
                done = 1'b1;
            end else if (rv) begin
                d = (use_crit && k == 0) ? crit : $urandom;
                bmain_rvalid = 1'b1;
                bmain_rdata  = d;
                bmain_rlast  = (k == L - 1) || (k == early);
                @(negedge clk_core);
                chk("beat_wr", 64'(o_wr), 64'(!killed));
                if (!killed) begin
                    chk("beat_way", 64'(o_way), 64'(vic));
                    chk("beat_off", 64'(o_off), 64'((a + k) % L));
                    chk("beat_tag", 64'(o_tag), 64'(a >> offw));
                    chk("beat_data", 64'(o_wdata), 64'(d));
                end
                chk("beat_lv", 64'(o_lv), 64'(!killed && k == L - 1));
                chk("beat_eack", 64'(o_eack), 0);
                chk("beat_rready", 64'(o_rr), 1);
                chk_pulses();
                if (o_wr) nwr++;
                if (k == 0) begin
                    exp_iv   = !killed;
                    exp_insn = d;
                end
                if (k == L - 1 || k == early) begin
                    exp_exc = (k != L - 1) && !killed;
                    if (k == L - 1 && !killed) vic = (vic + 1) % nw;
                    done = 1'b1;
                end
                k++;
            end else begin
                @(negedge clk_core);
                chk("gap_wr", 64'(o_wr), 0);
                chk("gap_rready", 64'(o_rr), 1);
                chk("gap_busy", 64'(o_busy), 1);
                chk_pulses();
            end
            step();
        end
        chk("burst_done", 64'(done), 1);
        chk("write_count", 64'(nwr), killed ? 0 : 64'(k));
        quiet_inputs();
    endtask

    function automatic int unsigned rand_addr(input int unsigned mask_low, input int unsigned off);
        return (($urandom & 32'h07FF_FFFF) & ~mask_low) | off;
    endfunction

    initial begin
        sel = 1'b0;
        vic = 0; exp_iv = 1'b0; exp_exc = 1'b0; exp_insn = '0;
        quiet_inputs();
        fill_addr = '0;
        reset_n = 1'b0;
        #23;
        chk_reset_outputs("rst");
        @(negedge clk_core);
        reset_n = 1'b1;
        step();
        idle_cycle();

        // 4-word line, 2 ways: critical-word-first wrap and round-robin victim.
        do_fill(rand_addr(3, 2), 0, 0, 0, -1, -1, -1, 1, 32'hDEADBEEF);
        do_fill(rand_addr(3, 1), 0, 0, 0, -1, -1, -1, 0, '0);
        do_fill(rand_addr(3, 3), 0, 0, 0, -1, -1, -1, 0, '0);
        // Command stall and sparse data.
        do_fill(rand_addr(3, 2), 5, 1, 0, -1, -1, -1, 0, '0);
        // Kill during command: drained, nothing written, victim unchanged.
        do_fill(rand_addr(3, 0), 0, 0, 1, -1, -1, -1, 0, '0);
        do_fill(rand_addr(3, 1), 1, 0, 0, -1, -1, -1, 0, '0);
        // Bus error on beat 1, then same way reused.
        do_fill(rand_addr(3, 2), 0, 0, 0, 1, -1, -1, 0, '0);
        do_fill(rand_addr(3, 0), 0, 0, 0, -1, -1, -1, 0, '0);
        // Early rlast on beat 2.
        do_fill(rand_addr(3, 3), 0, 0, 0, -1, 2, -1, 0, '0);
        idle_cycle();
        for (int i = 0; i < 6; i++) begin
            do_fill(rand_addr(0, 0), $urandom_range(0, 3), 2, 0, -1, -1, -1, 0, '0);
        end
        // Asynchronous reset mid-burst, then a clean start on way 0.
        do_fill(rand_addr(3, 1), 0, 0, 0, -1, -1, 2, 0, '0);
        step();
        do_fill(rand_addr(3, 2), 0, 0, 0, -1, -1, -1, 0, '0);
        idle_cycle();

        // 8-word line, 4 ways.
        sel = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_b");
        @(negedge clk_core);
        reset_n = 1'b1;
        vic = 0; exp_iv = 1'b0; exp_exc = 1'b0;
        step();
        idle_cycle();
        do_fill(rand_addr(7, 7), 0, 0, 0, -1, -1, -1, 1, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            do_fill(rand_addr(0, 0), $urandom_range(0, 2), 2, 0, -1, -1, -1, 0, '0);
        end
        do_fill(rand_addr(7, 5), 0, 0, 0, -1, 2, -1, 0, '0);
        do_fill(rand_addr(7, 6), 0, 1, 1, -1, -1, -1, 0, '0);
        do_fill(rand_addr(7, 3), 2, 0, 0, 3, -1, -1, 0, '0);
        do_fill(rand_addr(7, 4), 0, 0, 0, -1, -1, -1, 0, '0);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Parametrised instruction-cache line-refill engine for the fetch stage.
- Takes a miss (physical word address) from the fetch pipeline and issues one critical-word-first wrapping burst on the main bus.
- Writes each returned word into the selected CAM way, and delivers the requested instruction as soon as its beat arrives (early restart).
- Generalises the fixed 4-word, single-write-way fill: configurable line length and way count, round-robin victim selection, kill-drain and early-rlast checking.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- WAYS, 2, CAM ways; power of two, 1..8. WAYW = max(1, log2(WAYS)).
- PADDR_W, 29, physical address width. Word addresses are [PADDR_W-1:2]. OFFW = log2(LINE_WORDS).

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- fill_req  in  1  miss request, sampled only in IDLE
- fill_addr  in  PADDR_W-2  word address of the missing instruction
- kill  in  1  flush (branch mispredict / csr kill)
- icf_busy  out  1  fill in progress; fetch must stall
- icf_insn_valid  out  1  one-cycle pulse: icf_insn holds the requested word
- icf_insn  out  32  requested instruction; stable until the next fill's critical beat
- icf_exc  out  1  one-cycle pulse: bus error or protocol error on a live fill
- icf_cam_write_req  out  1  write one word into the CAM
- icf_cam_write_way  out  WAYW  victim way
- icf_cam_write_offset  out  OFFW  word offset within the line
- icf_cam_write_tag  out  PADDR_W-2-OFFW  line address
- icf_cam_write_data  out  32  word data
- icf_cam_line_valid  out  1  mark line valid; asserted with the final write
- icf_cvalid  out  1  bus command valid
- bmain_cready  in  1  bus command ready
- icf_cmd  out  1  constant 1 (read)
- icf_addr  out  PADDR_W-2  critical word address; bus wraps within the line
- bmain_rvalid  in  1  read data valid
- icf_rready  out  1  read data ready
- bmain_rlast  in  1  last beat
- bmain_rdata  in  32  read data
- bmain_error  in  1  bus error
- icf_eack  out  1  error acknowledge; equals bmain_error whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-low.
  - State = IDLE; beat count, killed flag and victim pointer = 0.
  - All outputs 0 except icf_cmd = 1. icf_insn = 0.
  - Reset mid-burst abandons the burst with no CAM writes.
- IDLE:
  - fill_req & ~kill: latch fill_addr, go to CMD; icf_busy = 1 from the next cycle.
  - fill_req & kill: ignored.
- CMD:
  - icf_cvalid = 1, icf_addr = latched address.
  - icf_cvalid is held until bmain_cready, even if kill arrives.
  - On handshake: go to DATA, beat count = 0.
- DATA: icf_rready = 1. Each beat (rvalid & rready):
  - offset = (latched[OFFW-1:0] + count) mod LINE_WORDS (wrap).
  - icf_cam_write_req = ~killed, with way = victim pointer, tag = latched line address, data = bmain_rdata. All are combinational in the beat cycle.
  - Beat 0 is the critical word. Register it into icf_insn; icf_insn_valid pulses the next cycle if not killed.
  - count == LINE_WORDS-1: requires bmain_rlast.
    - icf_cam_line_valid = ~killed.
    - If not killed, the victim pointer advances mod WAYS.
    - Go to IDLE; icf_busy drops the next cycle.
  - bmain_rlast on any earlier beat is a protocol error: icf_exc pulse (if not killed), no line_valid, go to IDLE.
- Kill: kill in CMD or DATA, or in the same cycle as the IDLE→CMD transition, sets killed.
  - The burst continues and is fully drained; killed beats are accepted but not written.
  - No insn_valid, line_valid or exc is produced for a killed fill.
  - The killed flag clears on return to IDLE.
  - kill in the cycle a critical beat arrives also suppresses that beat's insn_valid.
- bmain_error in CMD or DATA:
  - icf_eack = 1 in the same cycle; the burst is abandoned.
  - icf_exc pulses the next cycle unless killed.
  - Go to IDLE; no line_valid; the victim pointer is unchanged.
  - Words already written stay in the CAM but remain invalid.
- Latency (cready/rvalid always 1): req at cycle 0 → cvalid at 1 → beat 0 at 2 → insn_valid at 3 → final beat at LINE_WORDS+1 → busy low at LINE_WORDS+2.
- Back-to-back: a new fill_req is accepted in the first IDLE cycle.

Test Plan:
- LINE_WORDS=4, WAYS=2, fill_addr word offset 2, zero-wait bus → writes at offsets 2,3,0,1 to way 0. insn_valid at cycle 3 with beat-0 data 0xDEADBEEF. line_valid on the 4th beat. A second fill uses way 1; a third uses way 0.
- cready held low 5 cycles, rvalid toggling every other cycle → cvalid held stable for 5 cycles. Exactly 4 writes, in wrap order. busy drops only after the last beat.
- kill asserted during CMD → command still issued; 4 beats accepted with zero CAM writes. No insn_valid, line_valid or exc; victim pointer unchanged.
- bmain_error on beat 1 → eack in the same cycle, exc pulse next cycle, no line_valid, IDLE next. A following fill uses the same way.
- rlast on beat 2 with LINE_WORDS=4 → exc pulse, no line_valid. Repeat with LINE_WORDS=8, WAYS=4, offset 7 → write offsets 7,0..6, victim pointer cycles through 0..3.
- reset_n pulsed low mid-DATA (asynchronous, between clock edges) → all outputs 0 immediately. The next request starts cleanly at victim way 0.
